// File: rtl/rpn_token_sequencer.sv
// rpn_token_sequencer: buffers RPN tokens in a small FIFO and issues them to the
// microcoded 4-bit calculator as spaced push/func command pulses, tracking the
// operand-stack depth and returning each operator result on a one-cycle strobe.
module rpn_token_sequencer #(
   parameter int unsigned data_width    = 4,
   parameter int unsigned fifo_depth    = 8,
   parameter int unsigned settle_cycles = 4,
   parameter int unsigned stack_depth   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tok_valid,
   output logic                  tok_ready,
   input  logic                  tok_is_op,
   input  logic [data_width-1:0] tok_data,
   output logic                  calc_push,
   output logic                  calc_func,
   output logic [1:0]            calc_opcode,
   output logic [data_width-1:0] calc_data,
   input  logic [2:0]            calc_state,
   input  logic [data_width-1:0] calc_result,
   output logic                  res_valid,
   output logic [data_width-1:0] res_data,
   output logic [5:0]            depth,
   output logic                  err_underflow,
   output logic                  err_overflow,
   output logic                  busy
);

   localparam int unsigned aw = $clog2(fifo_depth);
   localparam int unsigned pw = aw + 1;
   localparam int unsigned cw = $clog2(settle_cycles + 1);

   localparam logic [pw-1:0] ptr_one     = pw'(1);
   localparam logic [cw-1:0] cnt_one     = cw'(1);
   localparam logic [cw-1:0] settle_load = cw'(settle_cycles);
   localparam logic [5:0]    depth_max   = 6'(stack_depth);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StIssue   = 2'd1;
   localparam logic [1:0] StWait    = 2'd2;
   localparam logic [1:0] StCapture = 2'd3;

   // Token FIFO: {is_op, data}; pointers carry one extra wrap bit.
   logic [data_width:0] fifo_mem [fifo_depth];
   logic [pw-1:0]       wr_ptr;
   logic [pw-1:0]       rd_ptr;
   logic [pw-1:0]       wr_vis;
   logic                fifo_full;
   logic                fifo_empty;
   logic                head_avail;
   logic                do_write;
   logic                do_pop;
   logic [data_width:0] head;

   logic [1:0]          state;
   logic                cur_is_op;
   logic [cw-1:0]       cnt;

   assign fifo_full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
   assign fifo_empty = (wr_ptr == rd_ptr);
   // The reader sees a write one cycle late, so the array needs no write-to-read bypass.
   assign head_avail = (rd_ptr != wr_vis);
   assign tok_ready  = !fifo_full;
   assign do_write   = tok_valid && tok_ready;
   assign do_pop     = (state == StIdle) && head_avail;
   assign head       = fifo_mem[rd_ptr[aw-1:0]];

   assign calc_push = (state == StIssue) && !cur_is_op;
   assign calc_func = (state == StIssue) && cur_is_op;
   assign busy      = (state != StIdle) || !fifo_empty;

   // Token storage write port.
   always_ff @(posedge clk) begin
      if (do_write) begin
         fifo_mem[wr_ptr[aw-1:0]] <= {tok_is_op, tok_data};
      end
   end

   // FIFO pointer bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_vis <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + ptr_one;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ptr_one;
         end
         wr_vis <= wr_ptr;
      end
   end

   // Command sequencing FSM with depth tracking, error flags and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         cur_is_op     <= 1'b0;
         cnt           <= '0;
         depth         <= '0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
         calc_opcode   <= '0;
         calc_data     <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (head_avail) begin
                  if (!head[data_width]) begin
                     if (depth == depth_max) begin
                        err_overflow <= 1'b1;
                     end else begin
                        calc_data <= head[data_width-1:0];
                        cur_is_op <= 1'b0;
                        state     <= StIssue;
                     end
                  end else begin
                     if (depth < 6'd2) begin
                        err_underflow <= 1'b1;
                     end else begin
                        calc_opcode <= head[1:0];
                        cur_is_op   <= 1'b1;
                        state       <= StIssue;
                     end
                  end
               end
            end
            StIssue: begin
               depth <= cur_is_op ? (depth - 6'd1) : (depth + 6'd1);
               cnt   <= settle_load;
               state <= StWait;
            end
            StWait: begin
               // Counter parks at zero while the calculator is still busy.
               if (cnt > cnt_one) begin
                  cnt <= cnt - cnt_one;
               end else begin
                  cnt <= '0;
                  if (calc_state == 3'd0) begin
                     state <= cur_is_op ? StCapture : StIdle;
                  end
               end
            end
            StCapture: begin
               res_data  <= calc_result;
               res_valid <= 1'b1;
               state     <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
